// File: rtl/oam_dma_arb.sv
// rtl/oam_dma_arb.sv - OAM DMA register/copy engine and CPU/DMA main-bus arbiter
// FFxx traffic always goes to the high bus so the CPU can run from HRAM during a copy.
module oam_dma_arb #(
  parameter logic [15:0] DMA_REG  = 16'hFF46,
  parameter logic [15:0] OAM_BASE = 16'hFE00,
  parameter int          DMA_LEN  = 160
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_write,
  output logic [7:0]  cpu_rdata,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_write,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  hi_addr,
  output logic [7:0]  hi_wdata,
  output logic        hi_write,
  input  logic [7:0]  hi_rdata,
  output logic        dma_active
);

  typedef enum logic [1:0] {S_IDLE, S_DELAY, S_READ, S_WRITE} state_t;

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] count_q, count_d;
  logic [7:0] data_q, data_d;

  logic        hi_page;
  logic        is_dma_reg;
  logic        dma_reg_wr;
  logic        bus_owned;
  logic [7:0]  src_page;
  logic [15:0] src_addr;
  logic [15:0] dst_addr;

  assign hi_page    = (cpu_addr[15:8] == 8'hFF);
  assign is_dma_reg = (cpu_addr == DMA_REG);
  assign dma_reg_wr = cpu_write && is_dma_reg;
  assign bus_owned  = (state_q == S_READ) || (state_q == S_WRITE);

  // Echo RAM: pages E0-FF alias C0-DF.
  assign src_page = (page_q >= 8'hE0) ? (page_q - 8'h20) : page_q;
  assign src_addr = {src_page, 8'h00} + {8'h00, count_q};
  assign dst_addr = OAM_BASE + {8'h00, count_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      page_q  <= 8'h00;
      count_q <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      count_q <= count_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    page_d  = page_q;
    count_d = count_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE:  state_d = S_IDLE;
      S_DELAY: state_d = S_READ;
      S_READ: begin
        data_d  = mem_rdata;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        count_d = count_q + 8'd1;
        state_d = (count_q == LAST_IDX) ? S_IDLE : S_READ;
      end
      default: state_d = S_IDLE;
    endcase
    // A register write restarts from any state; this cycle's bus action still happens.
    if (dma_reg_wr) begin
      page_d  = cpu_wdata;
      count_d = 8'h00;
      state_d = S_DELAY;
    end
  end

  always_comb begin
    hi_addr    = cpu_addr[7:0];
    hi_wdata   = cpu_wdata;
    hi_write   = rst && cpu_write && hi_page && !is_dma_reg;
    dma_active = rst && bus_owned;
    mem_addr   = cpu_addr;
    mem_wdata  = cpu_wdata;
    mem_write  = rst && !bus_owned && cpu_write && !hi_page;
    cpu_rdata  = mem_rdata;
    if (state_q == S_READ) begin
      mem_addr = src_addr;
    end else if (state_q == S_WRITE) begin
      mem_addr  = dst_addr;
      mem_wdata = data_q;
      mem_write = rst;
    end
    if (hi_page) begin
      cpu_rdata = is_dma_reg ? page_q : hi_rdata;
    end else if (bus_owned) begin
      cpu_rdata = 8'hFF;
    end
    if (!rst) begin
      mem_addr  = 16'h0000;
      cpu_rdata = 8'hFF;
    end
  end

endmodule

// File: tb/tb_oam_dma_arb.sv
// tb/tb_oam_dma_arb.sv - directed self-checking bench for oam_dma_arb
module tb_oam_dma_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_write;
  logic [7:0]  cpu_rdata;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_write;
  logic [7:0]  mem_rdata;
  logic [7:0]  hi_addr;
  logic [7:0]  hi_wdata;
  logic        hi_write;
  logic [7:0]  hi_rdata;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic        act_log  [0:399];
  logic        wr_log   [0:399];
  logic [15:0] addr_log [0:399];
  int          cyc;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  assign hi_rdata  = 8'h3C;

  oam_dma_arb dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .hi_addr(hi_addr), .hi_wdata(hi_wdata), .hi_write(hi_write), .hi_rdata(hi_rdata),
    .dma_active(dma_active)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    cpu_addr  = 16'h0000;
    cpu_wdata = 8'h00;
    cpu_write = 1'b0;
  endtask

  task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
    cpu_addr  = a;
    cpu_wdata = d;
    cpu_write = 1'b1;
  endtask

  // Sample mid-cycle, log, and apply the main-bus write to the memory model.
  task automatic sample();
    @(negedge clk);
    if (cyc < 400) begin
      act_log[cyc]  = dma_active;
      wr_log[cyc]   = mem_write;
      addr_log[cyc] = mem_addr;
    end
    if (mem_write) mem[mem_addr] = mem_wdata;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic start_test();
    for (int i = 0; i < 400; i++) begin
      act_log[i] = 1'b0;
      wr_log[i]  = 1'b0;
      addr_log[i] = 16'h0000;
    end
    for (int i = 0; i < 160; i++) mem[16'hFE00 + i] = 8'h00;
    cyc = 0;
  endtask

  int n_wr, n_act, last_wr, bad;

  task automatic tally(input int lo, input int hi);
    n_wr = 0; n_act = 0; last_wr = -1;
    for (int c = lo; c <= hi; c++) begin
      if (wr_log[c]) begin n_wr++; last_wr = c; end
      if (act_log[c]) n_act++;
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    rst = 1'b0;
    idle();
    cyc = 0;

    // 1: reset
    cpu_addr = 16'hFF46;
    sample();
    chk("rst_rdata_forced", {24'h0, cpu_rdata}, 32'hFF);
    chk("rst_active", {31'h0, dma_active}, 32'h0);
    adv();
    adv();
    rst = 1'b1;
    sample();
    chk("post_rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("post_rst_hi_write", {31'h0, hi_write}, 32'h0);
    chk("post_rst_active", {31'h0, dma_active}, 32'h0);
    chk("post_rst_ff46", {24'h0, cpu_rdata}, 32'h00);
    adv();

    // 2 + 3: basic copy with CPU traffic during DMA
    for (int i = 0; i < 160; i++) mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    mem[16'hC000] = 8'h11;
    start_test();
    for (int t = 0; t <= 330; t++) begin
      idle();
      if (t == 0)  cpu_wr(16'hFF46, 8'hC1);
      if (t == 10) cpu_addr = 16'hC000;
      if (t == 11) cpu_wr(16'hFF85, 8'hAA);
      if (t == 12) cpu_wr(16'hC000, 8'h77);
      sample();
      if (t == 10) chk("dma_cpu_read_ff", {24'h0, cpu_rdata}, 32'hFF);
      if (t == 11) begin
        chk("hi_write", {31'h0, hi_write}, 32'h1);
        chk("hi_addr", {24'h0, hi_addr}, 32'h85);
        chk("hi_wdata", {24'h0, hi_wdata}, 32'hAA);
      end
      if (t == 12) begin
        chk("dma_cpu_wr_blocked", {31'h0, mem_write}, 32'h0);
        chk("dma_src_addr_12", {16'h0, mem_addr}, 32'hC105);
      end
      adv();
    end
    idle();
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'h5A)) bad++;
    chk("copy_c1_bad_bytes", bad, 0);
    chk("copy_c1_fe9f", {24'h0, mem[16'hFE9F]}, 32'h9F ^ 32'h5A);
    chk("cpu_c000_intact", {24'h0, mem[16'hC000]}, 32'h11);
    tally(2, 321);
    chk("active_2_321", n_act, 320);
    chk("active_1", {31'h0, act_log[1]}, 32'h0);
    chk("active_322", {31'h0, act_log[322]}, 32'h0);
    tally(0, 330);
    chk("write_pulses", n_wr, 160);
    chk("last_write_cycle", last_wr, 321);
    chk("first_dst", {16'h0, addr_log[3]}, 32'hFE00);
    chk("last_dst", {16'h0, addr_log[321]}, 32'hFE9F);

    // 4: restart mid-transfer
    for (int i = 0; i < 160; i++) mem[16'hD000 + i] = 8'(i) ^ 8'hC3;
    start_test();
    for (int t = 0; t <= 380; t++) begin
      idle();
      if (t == 0)  cpu_wr(16'hFF46, 8'hC1);
      if (t == 50) cpu_wr(16'hFF46, 8'hD0);
      sample();
      adv();
    end
    idle();
    chk("restart_51_write", {31'h0, wr_log[51]}, 32'h0);
    chk("restart_51_active", {31'h0, act_log[51]}, 32'h0);
    chk("restart_52_src", {16'h0, addr_log[52]}, 32'hD000);
    tally(0, 380);
    chk("restart_pulses", n_wr, 184);
    chk("restart_last_write", last_wr, 371);
    bad = 0;
    for (int i = 0; i < 160; i++) if (mem[16'hFE00 + i] !== (8'(i) ^ 8'hC3)) bad++;
    chk("restart_bad_bytes", bad, 0);
    cpu_addr = 16'hFF46;
    sample();
    chk("restart_ff46", {24'h0, cpu_rdata}, 32'hD0);
    adv();

    // 5: echo page
    for (int i = 0; i < 160; i++) begin
      mem[16'hC200 + i] = 8'(i + 1);
      mem[16'hE200 + i] = 8'hEE;
    end
    start_test();
    for (int t = 0; t <= 330; t++) begin
      idle();
      if (t == 0) cpu_wr(16'hFF46, 8'hE2);
      sample();
      adv();
    end
    idle();
    chk("echo_src_first", {16'h0, addr_log[2]}, 32'hC200);
    chk("echo_src_last", {16'h0, addr_log[320]}, 32'hC29F);
    chk("echo_fe00", {24'h0, mem[16'hFE00]}, 32'h01);
    chk("echo_fe50", {24'h0, mem[16'hFE50]}, 32'h51);
    chk("echo_fe9f", {24'h0, mem[16'hFE9F]}, 32'hA0);

    // 6: reset mid-transfer
    start_test();
    for (int t = 0; t <= 120; t++) begin
      idle();
      if (t == 0) cpu_wr(16'hFF46, 8'hC1);
      rst = (t == 100) ? 1'b0 : 1'b1;
      sample();
      if (t == 100) chk("midrst_rdata_forced", {24'h0, cpu_rdata}, 32'hFF);
      adv();
    end
    rst = 1'b1;
    chk("midrst_99_write", {31'h0, wr_log[99]}, 32'h1);
    tally(101, 120);
    chk("midrst_no_writes", n_wr, 0);
    chk("midrst_no_active", n_act, 0);
    cpu_addr = 16'hFF46;
    sample();
    chk("midrst_ff46", {24'h0, cpu_rdata}, 32'h00);
    adv();
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
